// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, select encodings and BCD converter states for the display stage.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] SEL_MENU   = 2'd0;
    localparam logic [1:0] SEL_RUN    = 2'd1;
    localparam logic [1:0] SEL_SCORE  = 2'd2;
    localparam logic [1:0] SEL_TARGET = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} bcd_state_e;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 14-bit binary to 4-digit BCD, one double-dabble iteration per clock.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o,
    output logic        busy_o,
    output logic        done_o
);

    bcd_state_e  state_q, state_d;
    logic [29:0] sh_q, adj;
    logic [3:0]  cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start_i ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = cnt_q == 4'd13 ? ST_DONE : ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q != ST_IDLE;
        done_o = state_q == ST_DONE;
    end

    always_comb begin
        adj = sh_q;
        for (int k = 0; k < 4; k++)
            adj[14+4*k +: 4] = sh_q[14+4*k +: 4] >= 4'd5 ? sh_q[14+4*k +: 4] + 4'd3 : sh_q[14+4*k +: 4];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            sh_q  <= {16'd0, bin_i};
            cnt_q <= '0;
        end else if (state_q == ST_SHIFT) begin
            sh_q  <= adj << 1;
            cnt_q <= cnt_q + 4'd1;
        end

    assign bcd_o = sh_q[29:14];

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 4-digit multiplexed active-low 7-segment driver with sequential BCD conversion.
// Define SEG7_OVERFLOW_FLASH_EN to flash all digits with dp lit when number exceeds 9999.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] number,
    input  logic [1:0]  select,
    input  logic [1:0]  mode,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW    = $clog2(DWELL + 1);
    localparam int BW    = $clog2(HALF + 1);

    logic [13:0]   clamped, last_q;
    logic [15:0]   bcd, digit_q;
    logic          busy, done, start;
    logic [SW-1:0] scan_q;
    logic [BW-1:0] blink_q;
    logic [1:0]    idx_q;
    logic          blink_on_q, menu, ovf, blink_en, scan_wrap, blink_wrap;
    logic [3:0]    cur, blank;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          dp_d;

    assign clamped = number > 14'd9999 ? 14'd9999 : number;
    assign start   = !busy && clamped != last_q;
    assign menu    = select == SEL_MENU;
`ifdef SEG7_OVERFLOW_FLASH_EN
    assign ovf     = !menu && number > 14'd9999;
`else
    assign ovf     = 1'b0;
`endif
    assign blink_en   = menu || ovf;
    assign scan_wrap  = scan_q == SW'(DWELL - 1);
    assign blink_wrap = blink_q == BW'(HALF - 1);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (clamped),
        .bcd_o   (bcd),
        .busy_o  (busy),
        .done_o  (done)
    );

    // A digit is blank only when it and every digit to its left are zero.
    always_comb begin
        cur      = digit_q[idx_q*4 +: 4];
        blank[3] = digit_q[15:12] == 4'd0;
        blank[2] = blank[3] && digit_q[11:8] == 4'd0;
        blank[1] = blank[2] && digit_q[7:4] == 4'd0;
        blank[0] = 1'b0;
        seg_d    = menu ? (idx_q == 2'd0 ? seg_of({2'b00, mode}) : SEG_BLANK)
                        : (blank[idx_q] ? SEG_BLANK : seg_of(cur));
        an_d     = blink_en && !blink_on_q ? 4'hF : ~(4'b0001 << idx_q);
        dp_d     = !ovf;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_q     <= '0;
            digit_q    <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b1;
            seg        <= SEG_BLANK;
            an         <= 4'hF;
            dp         <= 1'b1;
        end else begin
            if (start) last_q <= clamped;
            if (done) digit_q <= bcd;
            scan_q     <= scan_wrap ? '0 : scan_q + 1'b1;
            if (scan_wrap) idx_q <= idx_q + 2'd1;
            blink_q    <= !blink_en || blink_wrap ? '0 : blink_q + 1'b1;
            blink_on_q <= !blink_en ? 1'b1 : blink_wrap ? !blink_on_q : blink_on_q;
            seg        <= seg_d;
            an         <= an_d;
            dp         <= dp_d;
        end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Downstream display stage of the reaction game. It consumes the game controller's number/select/mode outputs and drives the 4-digit multiplexed active-low 7-segment display. A sequential binary-to-BCD converter runs on every value change. Digits are scanned at a fixed rate, with leading-zero blanking and a blinking menu view.

Parameters:
CLK_HZ, 100000000, input clock frequency
SCAN_HZ, 1000, per-digit dwell rate; digit advances every CLK_HZ/SCAN_HZ cycles
BLINK_HZ, 2, menu blink rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
number  in  14  value to show (binary); values above 9999 are clamped
select  in  2  game phase: 0 menu, 1 counting, 2 score, 3 target
mode  in  2  difficulty (0..2); shown only in menu
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  4  digit anodes, active-low, an[3] leftmost (thousands)
dp  out  1  decimal point, active-low

Behaviour:
- Reset (async): seg=7'h7F, an=4'hF, dp=1, BCD digit register=0000, last_value=0, FSM IDLE, scan index=0, scan/blink counters=0, blink phase=on.
- Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: if clamped number != last_value, latch it into a shift register and last_value, then go to SHIFT.
- SHIFT: 14 double-dabble iterations, one per clk. Add 3 to any BCD nibble >=5, then shift left 1.
- DONE: write all 4 BCD nibbles to the digit register atomically (one cycle), then return to IDLE.
- Latency: digit register holds the new value 16 clk after the latching edge.
- Changes during SHIFT/DONE are ignored until IDLE. Worst case is 32 clk from change to display of the latest value. The display never shows a mixed old/new digit set.
- Clamp: number>9999 converts as 9999.
- Scan: counter wraps at CLK_HZ/SCAN_HZ-1. On wrap, the index advances 0->1->2->3->0.
- Index i drives an = ~(1<<i) and seg = code of digit i. Outputs are registered: one cycle after the index/digit change.
- Leading-zero blanking in number view: digit 3 is blank if zero. Digit 2 is blank if zero and digit 3 is blank. Same rule for digit 1. Digit 0 is always shown.
- Blank digit: seg=7'h7F, while its anode is still driven.
- select==0 (menu): digits 3..1 blank, digit 0 shows mode.
  - During blink-off phase an=4'hF.
  - Blink counter runs only in menu and resets to on-phase when leaving menu.
- select 1/2/3: number view, no blink.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- dp: constant 1 unless the optional feature is enabled.
- Mid-operation reset: all state returns to reset values immediately. The next post-reset nonzero number triggers a fresh conversion.

Optional Feature:
SEG7_OVERFLOW_FLASH_EN
- Defined: a number above 9999 shows 9999 with all four dp lit (dp=0 on every scanned digit) and the blink timer applied to all digits.
- Undefined: a clamped value displays steadily with dp=1. Clamping occurs in both cases.

Decomposition:
- Package seg7_pkg: 7-bit segment constants for 0-9 and BLANK; select encodings SEL_MENU=0, SEL_RUN=1, SEL_SCORE=2, SEL_TARGET=3; function digit-to-segment.
- Sub-module bin2bcd_seq (14-bit in, 16-bit BCD out, start/busy/done) holds the conversion FSM. The top holds change detection, scan, blink and output registers.

Test Plan:
Sim params for all scenarios: CLK_HZ=1000, SCAN_HZ=100 (10 clk per digit), BLINK_HZ=10 (50 clk per phase).
1. Reset, select=3, number=4721 -> digits 4,7,2,1 after 16 clk. Full scan sweep of 40 clk shows an 1110/1101/1011/0111 with the matching codes.
2. select=2, number=7 -> an[0] seg=1111000. Digits 3..1 blank (seg=7F) while their anodes are driven.
3. select=2, number=305 -> digit 1 shows 0 (1000000); digit 3 blank.
4. number 1234 then 5678 four cycles later -> the digit register shows 1234 and then 5678 by cycle 32, with no mixed value.
5. select=0, mode=2 -> digit 0 seg=0100100. an=4'hF for 50 clk alternating with scanning for 50 clk. Leaving menu restores steady display.
6. number=12000 -> shows 9999. With SEG7_OVERFLOW_FLASH_EN it flashes with dp=0. Assert rst mid-SHIFT -> seg=7F, an=F at once.
